// File: rtl/fruit_spawner.sv
// Fruit placement for the snake game: picks a random free grid cell from a free-running LFSR,
// holds the fruit until eaten or expired, then cools down and respawns.
module fruit_spawner #(
  parameter int unsigned CELL_LOG2      = 4,
  parameter int unsigned COLS           = 40,
  parameter int unsigned ROWS           = 30,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned LIFETIME_TICKS = 200,
  parameter int unsigned COOLDOWN_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] snake_x,
  input  logic [8:0] snake_y,
  input  logic       collision,
  input  logic [1:0] fruit_collision_type,
  output logic [9:0] fruit_x,
  output logic [8:0] fruit_y,
  output logic [1:0] fruit_type,
  output logic       fruit_valid,
  output logic [7:0] eaten_count,
  output logic       expired
);

  typedef enum logic [1:0] {StEmpty, StPick, StActive, StCooldown} state_e;

  localparam logic [9:0]  ParkX = 10'h3FF;
  localparam logic [8:0]  ParkY = 9'h1FF;
  localparam logic [15:0] LifeLoad = 16'(LIFETIME_TICKS);
  localparam logic [15:0] CoolLoad = 16'(COOLDOWN_TICKS);

  state_e      r_state, w_state_next;
  logic [15:0] r_lfsr, w_lfsr_next;
  logic [9:0]  r_fruit_x, w_fruit_x_next;
  logic [8:0]  r_fruit_y, w_fruit_y_next;
  logic [1:0]  r_fruit_type, w_fruit_type_next;
  logic [7:0]  r_eaten, w_eaten_next;
  logic        r_expired, w_expired_next;
  logic [15:0] r_life, w_life_next;
  logic [15:0] r_cool, w_cool_next;

  logic [5:0]  w_col;
  logic [4:0]  w_row;
  logic [9:0]  w_cand_x;
  logic [8:0]  w_cand_y;
  logic [1:0]  w_cand_type;
  logic        w_accept;
  logic        w_eat;

  // Fibonacci LFSR, taps 16,14,13,11; advances every clock.
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Candidate cell drawn from the current LFSR value.
  assign w_col       = r_lfsr[5:0];
  assign w_row       = r_lfsr[10:6];
  assign w_cand_x    = 10'(w_col) << CELL_LOG2;
  assign w_cand_y    = 9'(w_row) << CELL_LOG2;
  assign w_cand_type = (r_lfsr[12:11] == 2'b00) ? 2'b01 : r_lfsr[12:11];
  assign w_accept    = (32'(w_col) < COLS) && (32'(w_row) < ROWS) &&
                       !((w_cand_x == snake_x) && (w_cand_y == snake_y));

  assign w_eat = collision && (fruit_collision_type == r_fruit_type);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_next      = r_state;
    w_fruit_x_next    = r_fruit_x;
    w_fruit_y_next    = r_fruit_y;
    w_fruit_type_next = r_fruit_type;
    w_eaten_next      = r_eaten;
    w_expired_next    = 1'b0;
    w_life_next       = r_life;
    w_cool_next       = r_cool;
    unique case (r_state)
      StEmpty: w_state_next = StPick;
      StPick: begin
        if (w_accept) begin
          w_fruit_x_next    = w_cand_x;
          w_fruit_y_next    = w_cand_y;
          w_fruit_type_next = w_cand_type;
          w_life_next       = LifeLoad;
          w_state_next      = StActive;
        end
      end
      StActive: begin
        // Eating takes priority over expiry in the same clock.
        if (w_eat) begin
          if (r_eaten != 8'hFF) w_eaten_next = r_eaten + 8'd1;
          w_fruit_x_next    = ParkX;
          w_fruit_y_next    = ParkY;
          w_fruit_type_next = 2'b00;
          w_cool_next       = CoolLoad;
          w_state_next      = StCooldown;
        end else if (tick) begin
          if (r_life <= 16'd1) begin
            w_life_next       = 16'd0;
            w_expired_next    = 1'b1;
            w_fruit_x_next    = ParkX;
            w_fruit_y_next    = ParkY;
            w_fruit_type_next = 2'b00;
            w_cool_next       = CoolLoad;
            w_state_next      = StCooldown;
          end else begin
            w_life_next = r_life - 16'd1;
          end
        end
      end
      StCooldown: begin
        if (r_cool == 16'd0) begin
          w_state_next = StPick;
        end else if (tick) begin
          w_cool_next = r_cool - 16'd1;
          if (r_cool == 16'd1) w_state_next = StPick;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StEmpty;
      r_lfsr       <= LFSR_SEED;
      r_fruit_x    <= ParkX;
      r_fruit_y    <= ParkY;
      r_fruit_type <= 2'b00;
      r_eaten      <= 8'd0;
      r_expired    <= 1'b0;
      r_life       <= 16'd0;
      r_cool       <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_lfsr       <= w_lfsr_next;
      r_fruit_x    <= w_fruit_x_next;
      r_fruit_y    <= w_fruit_y_next;
      r_fruit_type <= w_fruit_type_next;
      r_eaten      <= w_eaten_next;
      r_expired    <= w_expired_next;
      r_life       <= w_life_next;
      r_cool       <= w_cool_next;
    end
  end

  assign fruit_x     = r_fruit_x;
  assign fruit_y     = r_fruit_y;
  assign fruit_type  = r_fruit_type;
  assign fruit_valid = (r_state == StActive);
  assign eaten_count = r_eaten;
  assign expired     = r_expired;

endmodule

// File: tb/tb_fruit_spawner.sv
// Scoreboard bench for fruit_spawner: predicted spawns are queued when the triggering stimulus
// is driven and popped when fruit_valid rises.
module tb_fruit_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [9:0] snake_x = 10'd0;
  logic [8:0] snake_y = 9'd0;
  logic       collision = 1'b0;
  logic [1:0] fruit_collision_type = 2'b00;
  logic [9:0] fruit_x;
  logic [8:0] fruit_y;
  logic [1:0] fruit_type;
  logic       fruit_valid;
  logic [7:0] eaten_count;
  logic       expired;

  int total = 0;
  int bad = 0;
  int exp_eaten = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] t;
    int         cyc;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_lfsr;

  fruit_spawner #(
    .CELL_LOG2(4), .COLS(40), .ROWS(30), .LFSR_SEED(SEED),
    .LIFETIME_TICKS(5), .COOLDOWN_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .snake_x(snake_x), .snake_y(snake_y),
    .collision(collision), .fruit_collision_type(fruit_collision_type),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_type(fruit_type),
    .fruit_valid(fruit_valid), .eaten_count(eaten_count), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR running in lockstep with the DUT's.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  // First acceptable candidate after start value s (candidate i is lfsr_next^i(s)).
  task automatic find_accept(input logic [15:0] s, input logic [9:0] sx, input logic [8:0] sy,
                             output logic [9:0] x, output logic [8:0] y, output logic [1:0] t,
                             output int n);
    logic [15:0] v;
    logic [9:0]  cx;
    logic [8:0]  cy;
    v = s; n = 0; x = 10'h3FF; y = 9'h1FF; t = 2'b00;
    for (int i = 1; i <= 1000; i++) begin
      v  = lfsr_next(v);
      cx = {v[5:0], 4'b0000};
      cy = {v[10:6], 4'b0000};
      if (v[5:0] < 6'd40 && v[10:6] < 5'd30 && !(cx == sx && cy == sy)) begin
        x = cx; y = cy; t = (v[12:11] == 2'b00) ? 2'b01 : v[12:11]; n = i;
        break;
      end
    end
  endtask

  task automatic predict(input logic [15:0] s);
    exp_t e;
    int   n;
    find_accept(s, snake_x, snake_y, e.x, e.y, e.t, n);
    e.cyc = n + 1;
    q.push_back(e);
  endtask

  // Called at the negedge where the spawn-triggering stimulus was driven.
  task automatic check_spawn(input string name);
    exp_t e;
    int   cycles;
    bit   found;
    cycles = 0; found = 0;
    e.x = 10'h3FF; e.y = 9'h1FF; e.t = 2'b00; e.cyc = -1;
    if (q.size() > 0) e = q.pop_front();
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      tick = 1'b0;
      cycles++;
      if (fruit_valid === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_timeout: fruit_valid not seen in %0d clks", name, cycles);
      return;
    end
    total++;
    if (cycles !== e.cyc) begin
      bad++;
      $display("FAIL %s_latency: got %0d clks expected %0d", name, cycles, e.cyc);
    end
    total++;
    if (fruit_x !== e.x) begin
      bad++;
      $display("FAIL %s_x: got %h expected %h", name, fruit_x, e.x);
    end
    total++;
    if (fruit_y !== e.y) begin
      bad++;
      $display("FAIL %s_y: got %h expected %h", name, fruit_y, e.y);
    end
    total++;
    if (fruit_type !== e.t) begin
      bad++;
      $display("FAIL %s_type: got %b expected %b", name, fruit_type, e.t);
    end
  endtask

  task automatic check_parked(input string name);
    total++;
    if (fruit_x !== 10'h3FF || fruit_y !== 9'h1FF || fruit_type !== 2'b00 ||
        fruit_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_parked: got x=%h y=%h t=%b v=%b expected 3ff 1ff 00 0", name, fruit_x,
               fruit_y, fruit_type, fruit_valid);
    end
    total++;
    if (eaten_count !== 8'(exp_eaten)) begin
      bad++;
      $display("FAIL %s_eaten: got %0d expected %0d", name, eaten_count, exp_eaten);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Two cooldown ticks then a third that releases PICK; spawn predicted from the LFSR phase.
  task automatic cooldown_respawn(input string name);
    do_tick();
    do_tick();
    total++;
    if (fruit_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_early: fruit_valid got %b expected 0 after 2 ticks", name, fruit_valid);
    end
    predict(m_lfsr);
    tick = 1'b1;
    check_spawn(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    check_parked("reset");
    total++;
    if (expired !== 1'b0) begin
      bad++;
      $display("FAIL reset_expired: got %b expected 0", expired);
    end
    predict(SEED);
    reset = 1'b0;
    check_spawn("first_spawn");
  endtask

  task automatic test_mismatch();
    collision = 1'b1;
    fruit_collision_type = (fruit_type == 2'b01) ? 2'b10 : 2'b01;
    @(negedge clk);
    collision = 1'b0;
    total++;
    if (fruit_valid !== 1'b1 || eaten_count !== 8'(exp_eaten)) begin
      bad++;
      $display("FAIL mismatch: got v=%b eaten=%0d expected v=1 eaten=%0d", fruit_valid,
               eaten_count, exp_eaten);
    end
  endtask

  task automatic test_eat();
    collision = 1'b1;
    fruit_collision_type = fruit_type;
    @(negedge clk);
    collision = 1'b0;
    exp_eaten++;
    check_parked("eat");
    // Collision while parked must be ignored.
    collision = 1'b1;
    fruit_collision_type = 2'b01;
    @(negedge clk);
    collision = 1'b0;
    check_parked("cooldown_collision");
    cooldown_respawn("eat_respawn");
  endtask

  task automatic test_expire();
    for (int i = 0; i < 4; i++) do_tick();
    total++;
    if (expired !== 1'b0 || fruit_valid !== 1'b1) begin
      bad++;
      $display("FAIL expire_early: got exp=%b v=%b expected 0 1", expired, fruit_valid);
    end
    do_tick();
    total++;
    if (expired !== 1'b1) begin
      bad++;
      $display("FAIL expire_pulse: got %b expected 1", expired);
    end
    check_parked("expire");
    @(negedge clk);
    total++;
    if (expired !== 1'b0) begin
      bad++;
      $display("FAIL expire_width: got %b expected 0", expired);
    end
    cooldown_respawn("expire_respawn");
  endtask

  task automatic test_collide_on_expiry();
    for (int i = 0; i < 4; i++) do_tick();
    tick = 1'b1;
    collision = 1'b1;
    fruit_collision_type = fruit_type;
    @(negedge clk);
    tick = 1'b0;
    collision = 1'b0;
    exp_eaten++;
    check_parked("collide_expiry");
    total++;
    if (expired !== 1'b0) begin
      bad++;
      $display("FAIL collide_expiry_expired: got %b expected 0", expired);
    end
    cooldown_respawn("collide_respawn");
  endtask

  task automatic test_reset_mid_and_reject();
    logic [9:0] x0;
    logic [8:0] y0;
    logic [1:0] t0;
    int         n0;
    #1;
    reset = 1'b1;
    #1;
    exp_eaten = 0;
    check_parked("reset_mid");
    q.delete();
    // Put the snake on the first cell the reseeded LFSR would otherwise accept.
    find_accept(SEED, 10'h3FF, 9'h1FF, x0, y0, t0, n0);
    snake_x = x0;
    snake_y = y0;
    predict(SEED);
    @(negedge clk);
    reset = 1'b0;
    check_spawn("reject");
    total++;
    if (fruit_x === snake_x && fruit_y === snake_y) begin
      bad++;
      $display("FAIL reject_on_head: got (%h,%h) expected not (%h,%h)", fruit_x, fruit_y,
               snake_x, snake_y);
    end
  endtask

  task automatic test_saturate();
    bit found;
    tick = 1'b1;
    for (int k = 0; k < 260; k++) begin
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        if (fruit_valid === 1'b1) found = 1;
        else @(negedge clk);
      end
      if (!found) begin
        total++;
        bad++;
        $display("FAIL saturate_timeout: no fruit at eat %0d", k);
        break;
      end
      collision = 1'b1;
      fruit_collision_type = fruit_type;
      @(negedge clk);
      collision = 1'b0;
      if (exp_eaten < 255) exp_eaten++;
    end
    tick = 1'b0;
    total++;
    if (eaten_count !== 8'(exp_eaten) || exp_eaten != 255) begin
      bad++;
      $display("FAIL saturate: got %0d expected 255", eaten_count);
    end
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_eat();
    test_expire();
    test_collide_on_expiry();
    test_reset_mid_and_reject();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fruit_spawner.md
Name: fruit_spawner

Overview:
- Produces the fruit position and type that the snake-head/fruit collision checker consumes, and reacts to that checker's collision result.
- Places fruit on a cell-aligned grid using a free-running LFSR and never places it on the snake head.
- Holds the fruit until it is eaten or its lifetime expires, then waits a cooldown and respawns.
- Sits between the game tick generator and the collision checker; its outputs also feed the VGA renderer.

Parameters:
- CELL_LOG2, 4, log2 of cell size in pixels (16-px cells).
- COLS, 40, grid columns; legal col 0..COLS-1.
- ROWS, 30, grid rows; legal row 0..ROWS-1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- LIFETIME_TICKS, 200, game ticks a fruit stays before expiring.
- COOLDOWN_TICKS, 3, game ticks with no fruit between despawn and next pick.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk game step strobe.
- snake_x  input  10  snake head x in pixels.
- snake_y  input  9  snake head y in pixels.
- collision  input  1  registered head/fruit match from the collision checker.
- fruit_collision_type  input  2  type reported with collision: 01 grow, 10 shrink, 11 extra life.
- fruit_x  output  10  fruit x in pixels; 10'h3FF when parked.
- fruit_y  output  9  fruit y in pixels; 9'h1FF when parked.
- fruit_type  output  2  01/10/11; 00 only when parked.
- fruit_valid  output  1  high in ACTIVE only.
- eaten_count  output  8  fruits eaten, saturates at 255.
- expired  output  1  one-clk pulse when a fruit times out.

Behaviour:
- Reset (async): state EMPTY; fruit_x=10'h3FF, fruit_y=9'h1FF, fruit_type=00, fruit_valid=0, eaten_count=0, expired=0, LFSR=LFSR_SEED, counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk regardless of state.
- States:
  - EMPTY: go to PICK the next clk.
  - PICK: one candidate per clk.
    - col=lfsr[5:0], row=lfsr[10:6], t=lfsr[12:11]; t=00 is mapped to 01.
    - Accept only if col<COLS, row<ROWS and {col<<CELL_LOG2, row<<CELL_LOG2} != {snake_x, snake_y}.
    - On accept, register fruit_x=col<<CELL_LOG2, fruit_y=row<<CELL_LOG2, fruit_type=t; load life counter with LIFETIME_TICKS; go to ACTIVE.
    - On reject, stay in PICK and retry next clk; no retry limit.
  - ACTIVE: fruit_valid=1; outputs stable.
    - If collision=1 and fruit_collision_type==fruit_type: increment eaten_count (saturating), park outputs, load cooldown with COOLDOWN_TICKS, go to COOLDOWN.
    - Else on tick, decrement life. When life reaches 0: pulse expired, park, go to COOLDOWN.
  - COOLDOWN: parked, fruit_valid=0. Decrement on tick; at 0 go to PICK. With COOLDOWN_TICKS=0, go to PICK the next clk.
- Registered outputs; fruit_valid rises the clk after acceptance.
- Collision is ignored outside ACTIVE. Parking off-field guarantees the checker's one-clk-late collision cannot retrigger.
- Collision and expiry in the same clk: collision wins; eaten_count increments, expired stays 0.
- collision=1 with mismatching type in ACTIVE: ignored.
- tick held high continuously: counts every clk.
- Reset mid-operation: returns immediately to the reset values above; the LFSR is reseeded.

Test Plan:
- Reset, then release with tick=0 and snake at (0,0) -> fruit_valid=1 within 70 clks; fruit_x, fruit_y multiples of 16; fruit_x≤624, fruit_y≤464; fruit_type≠00.
- Once ACTIVE, drive collision=1 with matching type for 1 clk -> next clk fruit_x=3FF, fruit_y=1FF, fruit_valid=0, eaten_count=1. With COOLDOWN_TICKS=3, a new fruit appears only after 3 ticks.
- LIFETIME_TICKS=5: issue 5 ticks in ACTIVE -> expired pulses exactly 1 clk on the 5th; eaten_count unchanged; respawn after cooldown.
- Set snake head equal to the next accepted candidate (force LFSR via seed) -> candidate rejected; the final fruit position differs from the snake head.
- Collision on the same clk as the final tick -> eaten_count increments, expired=0. Assert reset mid-ACTIVE -> outputs parked and eaten_count=0 immediately. Then 260 forced eats -> eaten_count=255.
